// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding bus requester feeding a small
// prefetch queue, with trap / trap-return / redirect steering of the fetch PC.
module fetch_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic [XLEN-1:0]        iInitialPC,
  // instruction bus
  output logic                   oIReq,
  output logic [XLEN-1:0]        oIAddr,
  input  logic                   iIGnt,
  input  logic                   iIRValid,
  input  logic [31:0]            iIRData,
  // consumer
  output logic                   oInstrValid,
  output logic [31:0]            oInstr,
  output logic [XLEN-1:0]        oInstrPC,
  input  logic                   iInstrReady,
  // redirects
  input  logic                   iRedirect,
  input  logic [XLEN-1:0]        iRedirectPC,
  input  logic                   iTrap,
  input  logic                   iTrapIntr,
  input  logic [4:0]             iTrapCause,
  input  logic [XLEN-1:0]        iUtvec,
  input  logic                   iUret,
  input  logic [XLEN-1:0]        iUepc,
  // monitoring
  output logic [XLEN-1:0]        oFetchPC,
  output logic [$clog2(DEPTH):0] oCount
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] pending_pc_reg;
  logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0]   count_reg, count_next, count_after_pop;
  logic            valid_reg;
  logic [31:0]     instr_reg;
  logic [XLEN-1:0] instr_pc_reg;
  logic            ireq_reg;

  logic [31:0]     mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];

  logic            flush, pop, push, granted;
  logic [XLEN-1:0] tvec_base, trap_target, flush_target;
  logic [31:0]     head_instr;
  logic [XLEN-1:0] head_pc;

  // Trap outranks trap-return, which outranks an ordinary redirect.
  always_comb begin
    tvec_base   = iUtvec & ALIGN_MASK;
    trap_target = tvec_base;
    if (iUtvec[1:0] == 2'b01 && iTrapIntr)
      trap_target = tvec_base + {{(XLEN-7){1'b0}}, iTrapCause, 2'b00};
    if (iTrap)
      flush_target = trap_target;
    else if (iUret)
      flush_target = iUepc & ALIGN_MASK;
    else
      flush_target = iRedirectPC & ALIGN_MASK;
  end

  assign flush   = iTrap | iUret | iRedirect;
  assign granted = (state_reg == REQ) && iIGnt;
  assign pop     = valid_reg & iInstrReady & ~flush;
  assign push    = (state_reg == WAIT) && iIRValid && !flush &&
                   ((count_reg != FULL_CNT) || pop);

  always_comb begin
    count_after_pop = count_reg - CW'(pop);
    if (flush) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end else begin
      count_next  = count_after_pop + CW'(push);
      rd_ptr_next = rd_ptr_reg + PW'(pop);
      wr_ptr_next = wr_ptr_reg + PW'(push);
    end
  end

  // The head register is loaded from the entry that will be at the head after
  // this edge; when the queue drains to nothing, that entry is the incoming word.
  always_comb begin
    if (count_after_pop == '0) begin
      head_instr = iIRData;
      head_pc    = pending_pc_reg;
    end else begin
      head_instr = mem_instr[rd_ptr_next];
      head_pc    = mem_pc[rd_ptr_next];
    end
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (flush)
      fetch_pc_next = flush_target;
    else if (granted)
      fetch_pc_next = fetch_pc_reg + XLEN'(4);
  end

  // A response arriving on the flush edge itself closes the transaction, so
  // only a still-outstanding one sends the FSM to DROP.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (flush || count_reg != FULL_CNT) state_next = REQ;
      REQ:  if (iIGnt) state_next = flush ? DROP : WAIT;
      WAIT: begin
        if (iIRValid)
          state_next = (count_next != FULL_CNT) ? REQ : IDLE;
        else if (flush)
          state_next = DROP;
      end
      DROP: if (iIRValid) state_next = flush ? REQ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_reg      <= IDLE;
      fetch_pc_reg   <= iInitialPC;
      pending_pc_reg <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
      valid_reg      <= 1'b0;
      instr_reg      <= '0;
      instr_pc_reg   <= '0;
      ireq_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if (granted)
        pending_pc_reg <= fetch_pc_reg;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      valid_reg  <= (count_next != '0);
      if (count_next != '0) begin
        instr_reg    <= head_instr;
        instr_pc_reg <= head_pc;
      end
      ireq_reg <= (state_next == REQ);
    end
  end

  // Queue storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge iCLK) begin
    if (push) begin
      mem_instr[wr_ptr_reg] <= iIRData;
      mem_pc[wr_ptr_reg]    <= pending_pc_reg;
    end
  end

  assign oIReq       = ireq_reg;
  assign oIAddr      = fetch_pc_reg;
  assign oFetchPC    = fetch_pc_reg;
  assign oInstrValid = valid_reg;
  assign oInstr      = instr_reg;
  assign oInstrPC    = instr_pc_reg;
  assign oCount      = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the bus model answers one cycle after each
// grant with the complement of the granted address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] initial_pc = 32'h0040_0000;
  logic        ireq;
  logic [31:0] iaddr;
  logic        ignt = 1'b0;
  logic        irvalid = 1'b0;
  logic [31:0] irdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        trap = 1'b0;
  logic        trap_intr = 1'b0;
  logic [4:0]  trap_cause = '0;
  logic [31:0] utvec = '0;
  logic        uret = 1'b0;
  logic [31:0] uepc = '0;
  logic [31:0] fetch_pc;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  logic        hold_resp = 1'b0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          req_count = 0;
  int          r0;

  fetch_unit #(.XLEN(32), .DEPTH(4)) dut (
    .iCLK(clk), .iRST(rst), .iInitialPC(initial_pc),
    .oIReq(ireq), .oIAddr(iaddr), .iIGnt(ignt), .iIRValid(irvalid), .iIRData(irdata),
    .oInstrValid(instr_valid), .oInstr(instr), .oInstrPC(instr_pc), .iInstrReady(instr_ready),
    .iRedirect(redirect), .iRedirectPC(redirect_pc),
    .iTrap(trap), .iTrapIntr(trap_intr), .iTrapCause(trap_cause), .iUtvec(utvec),
    .iUret(uret), .iUepc(uepc),
    .oFetchPC(fetch_pc), .oCount(count)
  );

  always #5 clk = ~clk;

  // Bus model, driven mid-cycle: grants whenever nothing is outstanding.
  always @(negedge clk) begin
    irvalid = 1'b0;
    if (pend && !hold_resp) begin
      irvalid = 1'b1;
      irdata  = ~pend_addr;
      pend    = 1'b0;
    end
    ignt = ireq && !pend;
    if (ignt) begin
      pend      = 1'b1;
      pend_addr = iaddr;
      req_count = req_count + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60 && instr_valid !== 1'b1; i++) step(1);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_ireq(input string tag);
    for (int i = 0; i < 60 && ireq !== 1'b1; i++) step(1);
    chk({tag, "_ireq"}, 32'(ireq), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_ireq", 32'(ireq), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_fetchpc", fetch_pc, 32'h0040_0000);

    // Start-up stream with a consumer that is always ready.
    rst = 1'b0;
    instr_ready = 1'b1;
    step(1);
    chk("first_ireq", 32'(ireq), 32'd1);
    chk("first_addr", iaddr, 32'h0040_0000);
    step(2);
    chk("v0_valid", 32'(instr_valid), 32'd1);
    chk("v0_pc", instr_pc, 32'h0040_0000);
    chk("v0_instr", instr, 32'hFFBF_FFFF);
    chk("v0_count", 32'(count), 32'd1);
    chk("v0_fetchpc", fetch_pc, 32'h0040_0004);
    step(1);
    wait_valid("v1");
    chk("v1_pc", instr_pc, 32'h0040_0004);
    chk("v1_instr", instr, 32'hFFBF_FFFB);
    step(1);
    wait_valid("v2");
    chk("v2_pc", instr_pc, 32'h0040_0008);
    chk("v2_instr", instr, 32'hFFBF_FFF7);

    // Stall the consumer until the queue is full.
    instr_ready = 1'b0;
    step(20);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ireq", 32'(ireq), 32'd0);
    chk("full_head", instr_pc, 32'h0040_0008);
    r0 = req_count;
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    chk("pop_count", 32'(count), 32'd3);
    chk("pop_head", instr_pc, 32'h0040_000C);
    chk("pop_instr", instr, 32'hFFBF_FFF3);
    step(10);
    chk("refill_count", 32'(count), 32'd4);
    chk("refill_reqs", 32'(req_count - r0), 32'd1);
    chk("refill_ireq", 32'(ireq), 32'd0);
    chk("refill_fetchpc", fetch_pc, 32'h0040_001C);

    // Redirect while a granted response is held back by the bus.
    hold_resp = 1'b1;
    r0 = req_count;
    instr_ready = 1'b1;
    step(1);
    instr_ready = 1'b0;
    step(3);
    chk("pend_ireq", 32'(ireq), 32'd0);
    chk("pend_count", 32'(count), 32'd3);
    chk("pend_reqs", 32'(req_count - r0), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h0040_0103;
    step(1);
    redirect = 1'b0;
    chk("drop_valid", 32'(instr_valid), 32'd0);
    chk("drop_count", 32'(count), 32'd0);
    chk("drop_fetchpc", fetch_pc, 32'h0040_0100);
    chk("drop_ireq", 32'(ireq), 32'd0);
    step(3);
    chk("drop_hold_ireq", 32'(ireq), 32'd0);
    hold_resp = 1'b0;
    wait_ireq("redir");
    chk("redir_addr", iaddr, 32'h0040_0100);
    wait_valid("redir");
    chk("redir_pc", instr_pc, 32'h0040_0100);
    chk("redir_instr", instr, 32'hFFBF_FEFF);
    chk("redir_count", 32'(count), 32'd1);

    // Vectored interrupt, then the same vector for a non-interrupt trap.
    utvec = 32'h0040_0201;
    trap_intr = 1'b1;
    trap_cause = 5'd4;
    trap = 1'b1;
    step(1);
    trap = 1'b0;
    chk("vec_fetchpc", fetch_pc, 32'h0040_0210);
    chk("vec_count", 32'(count), 32'd0);
    chk("vec_valid_low", 32'(instr_valid), 32'd0);
    wait_ireq("vec");
    chk("vec_addr", iaddr, 32'h0040_0210);
    wait_valid("vec");
    chk("vec_pc", instr_pc, 32'h0040_0210);
    chk("vec_instr", instr, 32'hFFBF_FDEF);
    trap_intr = 1'b0;
    trap = 1'b1;
    step(1);
    trap = 1'b0;
    chk("direct_fetchpc", fetch_pc, 32'h0040_0200);
    wait_ireq("direct");
    chk("direct_addr", iaddr, 32'h0040_0200);
    wait_valid("direct");
    chk("direct_pc", instr_pc, 32'h0040_0200);

    // Trap return beats a concurrent redirect.
    uret = 1'b1;
    uepc = 32'h0040_0602;
    redirect = 1'b1;
    redirect_pc = 32'h0040_0500;
    step(1);
    uret = 1'b0;
    redirect = 1'b0;
    chk("uret_fetchpc", fetch_pc, 32'h0040_0600);
    wait_valid("uret");
    chk("uret_pc", instr_pc, 32'h0040_0600);

    // All three events together, on an edge that also pushes and pops.
    for (int i = 0; i < 40 && count !== 3'd2; i++) step(1);
    chk("sim_pre_count", 32'(count), 32'd2);
    step(1);
    trap = 1'b1;
    uret = 1'b1;
    redirect = 1'b1;
    utvec = 32'h0040_0301;
    trap_intr = 1'b1;
    trap_cause = 5'd3;
    uepc = 32'h0040_0400;
    redirect_pc = 32'h0040_0500;
    instr_ready = 1'b1;
    step(1);
    trap = 1'b0;
    uret = 1'b0;
    redirect = 1'b0;
    chk("sim_count", 32'(count), 32'd0);
    chk("sim_valid", 32'(instr_valid), 32'd0);
    chk("sim_fetchpc", fetch_pc, 32'h0040_030C);
    wait_ireq("sim");
    chk("sim_addr", iaddr, 32'h0040_030C);
    wait_valid("sim");
    chk("sim_pc", instr_pc, 32'h0040_030C);
    instr_ready = 1'b0;

    // Reset with three entries queued and a response outstanding.
    for (int i = 0; i < 40 && count !== 3'd3; i++) step(1);
    chk("mid_pre_count", 32'(count), 32'd3);
    hold_resp = 1'b1;
    step(3);
    chk("mid_count", 32'(count), 32'd3);
    chk("mid_ireq", 32'(ireq), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst2_count", 32'(count), 32'd0);
    chk("rst2_valid", 32'(instr_valid), 32'd0);
    chk("rst2_ireq", 32'(ireq), 32'd0);
    chk("rst2_fetchpc", fetch_pc, 32'h0040_0000);
    step(2);
    rst = 1'b0;
    hold_resp = 1'b0;
    wait_valid("refetch");
    chk("refetch_pc", instr_pc, 32'h0040_0000);
    chk("refetch_instr", instr, 32'hFFBF_FFFF);
    chk("refetch_count", 32'(count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
